// File: rtl/bias_update_module.sv
// Bias register bank: read-add-write commit of the accumulator delta on COMMIT_CODE.
// BIAS_UPD_SAT_EN selects a saturating add with a sticky sat_flag; undefined wraps.
module bias_update_module #(
    parameter int                 NUM_BIAS    = 4,
    parameter int                 IDX_W       = 2,
    parameter logic [3:0]         COMMIT_CODE = 4'd10,
    parameter logic signed [15:0] INIT_BIAS   = 16'sd0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [3:0]              step,
    input  logic [3:0]              controller,
    input  logic signed [15:0]      deltab,
    input  logic [IDX_W-1:0]        upd_idx,
    input  logic [IDX_W-1:0]        rd_idx,
    output logic signed [15:0]      rd_bias,
    output logic                    busy,
    output logic                    done,
    output logic                    idx_err,
    output logic                    sat_flag
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_READ  = 3'd1;
    localparam logic [2:0] S_ADD   = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [IDX_W:0] NB = (IDX_W + 1)'(NUM_BIAS);

`ifdef BIAS_UPD_SAT_EN
    localparam int SW = 17;
`else
    localparam int SW = 16;
`endif

    logic [2:0]               state;
    logic [2:0]               nxt;
    logic                     ctl_q;
    logic                     code_hit;
    logic                     trig;
    logic                     i_bad;
    logic [IDX_W-1:0]         i_q;
    logic signed [15:0]       d_q;
    logic signed [15:0]       b_q;
    logic signed [15:0]       b_rd;
    logic signed [15:0]       rd_mux;
    logic signed [15:0]       res;
    logic signed [SW-1:0]     s_q;
    logic signed [15:0]       bias [NUM_BIAS];

    assign code_hit = (controller == COMMIT_CODE);
    assign trig     = code_hit && !ctl_q && (step != 4'd1);
    assign i_bad    = ({1'b0, i_q} >= NB);

    always_comb begin
        nxt = S_IDLE;
        unique case (state)
            S_IDLE:  nxt = trig ? S_READ : S_IDLE;
            S_READ:  nxt = S_ADD;
            S_ADD:   nxt = S_WRITE;
            S_WRITE: nxt = S_DONE;
            S_DONE:  nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    // Out-of-range indices read as zero and match no register on write.
    always_comb begin
        b_rd = 16'sd0;
        for (int k = 0; k < NUM_BIAS; k++) begin
            if (i_q == IDX_W'(k)) begin
                b_rd = bias[k];
            end
        end
    end

    always_comb begin
        rd_mux = 16'sd0;
        for (int k = 0; k < NUM_BIAS; k++) begin
            if (rd_idx == IDX_W'(k)) begin
                rd_mux = bias[k];
            end
        end
    end

`ifdef BIAS_UPD_SAT_EN
    logic sat;

    // Bits 16 and 15 disagree only when the 17-bit sum left the Q6.10 range.
    always_comb begin
        sat = 1'b0;
        res = s_q[15:0];
        if (s_q[16] != s_q[15]) begin
            sat = 1'b1;
            res = s_q[16] ? 16'sh8000 : 16'sh7FFF;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sat_flag <= 1'b0;
        end else if (state == S_WRITE && sat) begin
            sat_flag <= 1'b1;
        end else if (step == 4'd1) begin
            sat_flag <= 1'b0;
        end
    end
`else
    assign res      = s_q;
    assign sat_flag = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            idx_err <= 1'b0;
            ctl_q   <= 1'b0;
            i_q     <= '0;
            d_q     <= 16'sd0;
            b_q     <= 16'sd0;
            s_q     <= '0;
        end else begin
            state   <= nxt;
            busy    <= (nxt != S_IDLE);
            done    <= (nxt == S_DONE);
            idx_err <= (nxt == S_DONE) && i_bad;
            ctl_q   <= code_hit;
            if (state == S_IDLE && trig) begin
                d_q <= deltab;
                i_q <= upd_idx;
            end
            if (state == S_READ) begin
                b_q <= b_rd;
            end
            if (state == S_ADD) begin
                s_q <= SW'(b_q) + SW'(d_q);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NUM_BIAS; k++) begin
                bias[k] <= INIT_BIAS;
            end
            rd_bias <= INIT_BIAS;
        end else begin
            for (int k = 0; k < NUM_BIAS; k++) begin
                if (state == S_WRITE && i_q == IDX_W'(k)) begin
                    bias[k] <= res;
                end
            end
            rd_bias <= rd_mux;
        end
    end

endmodule

// File: tb/tb_bias_update_module.sv
// Directed bench for bias_update_module (NUM_BIAS = 3 so index 3 is out of range).
// Expectations follow BIAS_UPD_SAT_EN when it is defined for the build.
module tb_bias_update_module;

`ifdef BIAS_UPD_SAT_EN
    localparam logic SAT_ON = 1'b1;
`else
    localparam logic SAT_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  step;
    logic [3:0]  controller;
    logic [15:0] deltab;
    logic [1:0]  upd_idx;
    logic [1:0]  rd_idx;
    logic [15:0] rd_bias;
    logic        busy;
    logic        done;
    logic        idx_err;
    logic        sat_flag;

    int total = 0;
    int bad   = 0;

    bias_update_module #(
        .NUM_BIAS(3),
        .IDX_W(2),
        .COMMIT_CODE(4'd10),
        .INIT_BIAS(16'sd0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .step(step),
        .controller(controller),
        .deltab(deltab),
        .upd_idx(upd_idx),
        .rd_idx(rd_idx),
        .rd_bias(rd_bias),
        .busy(busy),
        .done(done),
        .idx_err(idx_err),
        .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic [1:0]  idx;
        logic [15:0] d;
        logic [15:0] exp;
        logic        err;
    } vec_t;

    vec_t tbl[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic rd(input logic [1:0] idx, output logic [15:0] v);
        rd_idx = idx;
        tick();
        v = rd_bias;
    endtask

    task automatic commit(input logic [1:0] idx, input logic [15:0] d,
                          output int lat, output logic err);
        upd_idx    = idx;
        deltab     = d;
        controller = 4'd10;
        lat        = -1;
        err        = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            tick();
            if (done) begin
                lat = n;
                err = idx_err;
                break;
            end
        end
        controller = 4'd9;
        tick();
    endtask

    initial begin
        int          lat;
        int          ndone;
        logic        err;
        logic [15:0] v;

        tbl[0] = '{2'd0, 16'h0066, 16'h0066, 1'b0};
        tbl[1] = '{2'd1, 16'h0400, 16'h0400, 1'b0};
        tbl[2] = '{2'd0, 16'hFF00, 16'hFF66, 1'b0};
        tbl[3] = '{2'd2, 16'h7F00, 16'h7F00, 1'b0};
        tbl[4] = '{2'd3, 16'h0100, 16'h0000, 1'b1};
        tbl[5] = '{2'd1, 16'hFC00, 16'h0000, 1'b0};

        rst        = 1'b0;
        step       = 4'd2;
        controller = 4'd9;
        deltab     = 16'h0;
        upd_idx    = 2'd0;
        rd_idx     = 2'd0;
        tick();
        tick();
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset idx_err", idx_err, 0);
        chk("reset sat_flag", sat_flag, 0);
        chk("reset rd_bias", rd_bias, 16'h0000);
        rst = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) begin
            commit(tbl[i].idx, tbl[i].d, lat, err);
            chk($sformatf("vec%0d latency", i), lat, 4);
            chk($sformatf("vec%0d idx_err", i), err, tbl[i].err);
            chk($sformatf("vec%0d done pulse width", i), done, 0);
            rd(tbl[i].idx, v);
            chk($sformatf("vec%0d bias", i), v, tbl[i].exp);
        end
        rd(2'd0, v);
        chk("final bias0", v, 16'hFF66);
        rd(2'd1, v);
        chk("final bias1", v, 16'h0000);
        rd(2'd2, v);
        chk("final bias2", v, 16'h7F00);
        chk("no saturation yet", sat_flag, 0);

        // Code held for six cycles: exactly one commit.
        ndone      = 0;
        upd_idx    = 2'd1;
        deltab     = 16'h0400;
        controller = 4'd10;
        for (int n = 0; n < 6; n++) begin
            tick();
            if (n == 0) chk("held busy", busy, 1);
            if (done) ndone++;
        end
        controller = 4'd9;
        for (int n = 0; n < 6; n++) begin
            tick();
            if (done) ndone++;
        end
        chk("held done count", ndone, 1);
        rd(2'd1, v);
        chk("held bias1", v, 16'h0400);

        // Positive overflow on bias2.
        commit(2'd2, 16'h0200, lat, err);
        chk("sat+ latency", lat, 4);
        rd(2'd2, v);
        chk("sat+ bias2", v, SAT_ON ? 16'h7FFF : 16'h8100);
        chk("sat+ flag", sat_flag, SAT_ON);

        step = 4'd1;
        tick();
        step = 4'd2;
        chk("step1 clears flag", sat_flag, 0);

        // Saturating WRITE coincident with step == 1: set wins.
        upd_idx    = 2'd2;
        deltab     = 16'h0100;
        controller = 4'd10;
        tick();
        tick();
        tick();
        step = 4'd1;
        tick();
        step = 4'd2;
        chk("set-vs-clear done", done, 1);
        chk("set-vs-clear flag", sat_flag, SAT_ON);
        controller = 4'd9;
        tick();
        chk("flag sticky", sat_flag, SAT_ON);
        rd(2'd2, v);
        chk("set-vs-clear bias2", v, SAT_ON ? 16'h7FFF : 16'h8200);

        // Negative overflow on bias1.
        commit(2'd1, 16'hFC00, lat, err);
        commit(2'd1, 16'h8100, lat, err);
        rd(2'd1, v);
        chk("neg setup bias1", v, 16'h8100);
        step = 4'd1;
        tick();
        step = 4'd2;
        commit(2'd1, 16'hFE00, lat, err);
        rd(2'd1, v);
        chk("sat- bias1", v, SAT_ON ? 16'h8000 : 16'h7F00);
        chk("sat- flag", sat_flag, SAT_ON);

        rd(2'd3, v);
        chk("oob readback", v, 16'h0000);

        // Reset asserted during ADD.
        upd_idx    = 2'd0;
        deltab     = 16'h0100;
        controller = 4'd10;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("midop busy", busy, 0);
        chk("midop done", done, 0);
        chk("midop sat_flag", sat_flag, 0);
        controller = 4'd9;
        tick();
        chk("midop rd_bias", rd_bias, 16'h0000);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            rd(2'(k), v);
            chk($sformatf("post-reset bias%0d", k), v, 16'h0000);
        end
        commit(2'd0, 16'h0066, lat, err);
        chk("fresh latency", lat, 4);
        chk("fresh idx_err", err, 0);
        rd(2'd0, v);
        chk("fresh bias0", v, 16'h0066);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bias_update_module.md
Name: bias_update_module

Overview:
- Downstream of the delta-bias accumulator. Consumes its Q6.10 delta-bias sum (deltab) and commits it into a bank of bias registers at the end of each training step.
- Each commit is a read-add-write with saturation. Updated biases are exposed through a registered readback port for the forward-pass datapath.
- One commit per entry of controller into the commit code. The FSM is sequenced by the shared step/controller bus.

Parameters:
- NUM_BIAS, 4, number of bias registers (index width IDX_W = 2 for default).
- IDX_W, 2, width of index ports; must satisfy 2**IDX_W >= NUM_BIAS.
- COMMIT_CODE, 4'd10, controller value that requests a commit.
- INIT_BIAS, 16'sd0, reset value of every bias register (Q6.10).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-low (rst = 0 resets).
- step  input  4  training step number; 4'd1 marks the start of a new step.
- controller  input  4  phase code shared with the accumulator.
- deltab  input  16  signed Q6.10 delta bias from the accumulator.
- upd_idx  input  IDX_W  bias index to update; sampled at commit detect.
- rd_idx  input  IDX_W  readback index.
- rd_bias  output  16  signed Q6.10 bias[rd_idx], registered.
- busy  output  1  high while the FSM is not in IDLE.
- done  output  1  one-cycle pulse when a commit finishes.
- idx_err  output  1  one-cycle pulse, coincident with done, when upd_idx >= NUM_BIAS.
- sat_flag  output  1  sticky: a commit saturated since the last step == 1.

Behaviour:
- Reset (rst = 0, asynchronous): every bias register = INIT_BIAS; FSM = IDLE; rd_bias = INIT_BIAS; busy = 0; done = 0; idx_err = 0; sat_flag = 0; ctl_q (registered copy of controller == COMMIT_CODE) = 0.
- Commit detect: trig = (controller == COMMIT_CODE) && !ctl_q && (step != 4'd1). This is a rising edge of the code match, so holding the code for N cycles gives exactly one commit.
- Busy handling: a trig while not IDLE is dropped (no queueing).
- FSM, one state per cycle:
  - IDLE: on trig, latch d_q = deltab and i_q = upd_idx, then go to READ.
  - READ: b_q = bias[i_q], or 0 if i_q >= NUM_BIAS; go to ADD.
  - ADD: s17 = sign-extended b_q + sign-extended d_q (17-bit); go to WRITE.
  - WRITE: if i_q < NUM_BIAS, bias[i_q] = result; otherwise no write. Go to DONE.
  - DONE: done = 1; idx_err = (i_q >= NUM_BIAS); go to IDLE.
- Latency: done is asserted 4 cycles after the trig cycle. The earliest next trig is the cycle after DONE.
- Result (with saturation): s17 > 32767 gives 16'h7FFF; s17 < -32768 gives 16'h8000; otherwise s17[15:0]. Saturation sets sat_flag in WRITE.
- sat_flag clears on any cycle with step == 4'd1. If a set and a clear occur in the same cycle, the set wins.
- step == 1 during an operation does not abort it.
- rd_bias <= bias[rd_idx] each cycle, or 0 if rd_idx >= NUM_BIAS. A readback of the index being written in WRITE returns the new value one cycle later.
- busy = (state != IDLE), registered with the state.
- Reset asserted mid-operation: the operation is abandoned, no partial write is kept, and all reset values apply.

Optional Feature:
- Macro: BIAS_UPD_SAT_EN.
- Defined: saturating add as above; sat_flag is functional.
- Undefined: the result is s17[15:0] (two's-complement wrap) and sat_flag is tied to 0.

Test Plan:
- Basic commit: after reset, upd_idx = 0, deltab = 16'h0066, controller 9 -> 10 -> expect done 4 cycles after trig, bias[0] = 16'h0066, sat_flag = 0, idx_err = 0.
- Held code: controller held at 10 for 6 cycles with deltab = 16'h0400 on idx 1 -> exactly one done; bias[1] = 16'h0400.
- Saturation (macro on): bias[2] brought to 16'h7F00, then commit deltab = 16'h0200 -> bias[2] = 16'h7FFF, sat_flag = 1. Then commit 16'hFE00 onto a bias of 16'h8100 -> 16'h8000. With the macro off, 16'h7F00 + 16'h0200 -> 16'h8100 and sat_flag stays 0.
- sat_flag clear: with sat_flag = 1, drive step = 1 for one cycle -> sat_flag = 0. A saturating WRITE in the same cycle as step == 1 -> sat_flag = 1.
- Bad index: upd_idx = 3 with NUM_BIAS = 3, commit deltab = 16'h0100 -> done and idx_err pulse together; all biases unchanged.
- Reset mid-op: trig, then rst = 0 during ADD -> busy = 0 immediately and all biases = INIT_BIAS. A fresh trig after release -> normal 4-cycle commit.
